// File: rtl/fetch_queue_unit_if.sv
// Fetch front-end bus: redirect input, instruction-memory request/response
// channels and the decode-facing instruction channel.
interface fetch_queue_unit_if #(
    parameter int ADDR_W = 8,
    parameter int WIDTH  = 32
);
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_addr;

    logic              imem_req_valid;
    logic [ADDR_W-1:0] imem_req_addr;
    logic              imem_req_ready;
    logic              imem_rsp_valid;
    logic [WIDTH-1:0]  imem_rsp_data;

    logic              out_valid;
    logic              out_ready;
    logic [5:0]        out_opcode;
    logic [4:0]        out_rs;
    logic [4:0]        out_rt;
    logic [15:0]       out_imm;
    logic [ADDR_W-1:0] out_pc;
    logic [ADDR_W-1:0] out_pc_next;

    modport master (
        input  redirect_valid, redirect_addr,
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output out_valid,
        input  out_ready,
        output out_opcode, out_rs, out_rt, out_imm, out_pc, out_pc_next
    );

    modport slave (
        output redirect_valid, redirect_addr,
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  out_valid,
        output out_ready,
        input  out_opcode, out_rs, out_rt, out_imm, out_pc, out_pc_next
    );
endinterface

// File: rtl/fetch_queue_unit.sv
// Instruction fetch front end: PC, credit-limited sequential fetch, prefetch
// queue of in-order responses and redirect flush with stale-response dropping.
module fetch_queue_unit #(
    parameter int ADDR_W   = 8,
    parameter int QDEPTH   = 4,
    parameter int PC_STEP  = 4,
    parameter int RESET_PC = 0,
    parameter int WIDTH    = 32
) (
    input logic               clk,
    input logic               rst,
    fetch_queue_unit_if.master bus
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);
    localparam logic [ADDR_W-1:0] RPC  = ADDR_W'(RESET_PC);
    localparam logic [CW:0]       CAP  = (CW + 1)'(QDEPTH);

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] rsp_pc;
    logic [CW-1:0]     count;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     outstanding_nxt;
    logic [CW-1:0]     drop;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;

    logic [WIDTH-1:0]  instr_q [QDEPTH];
    logic [ADDR_W-1:0] pc_q    [QDEPTH];

    logic req_valid;
    logic accept;
    logic pop;
    logic discard;
    logic push;

    // Stale in-flight requests still hold a slot's worth of credit, so the
    // queue can never be asked to take more than QDEPTH entries.
    always_comb begin
        req_valid       = rst && (({1'b0, count} + {1'b0, outstanding}) < CAP);
        accept          = req_valid && bus.imem_req_ready;
        pop             = (count != '0) && bus.out_ready;
        discard         = bus.imem_rsp_valid && ((drop != '0) || bus.redirect_valid);
        push            = bus.imem_rsp_valid && !discard;
        outstanding_nxt = outstanding + CW'(accept) - CW'(bus.imem_rsp_valid);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc    <= RPC;
            rsp_pc      <= RPC;
            count       <= '0;
            outstanding <= '0;
            drop        <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else if (bus.redirect_valid) begin
            fetch_pc    <= bus.redirect_addr;
            rsp_pc      <= bus.redirect_addr;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            outstanding <= outstanding_nxt;
            drop        <= outstanding_nxt;
        end else begin
            outstanding <= outstanding_nxt;
            count       <= count + CW'(push) - CW'(pop);
            if (accept)
                fetch_pc <= fetch_pc + STEP;
            if (discard)
                drop <= drop - CW'(1);
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
                rsp_pc <= rsp_pc + STEP;
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < QDEPTH; i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
            end
        end else if (push) begin
            instr_q[wr_ptr] <= bus.imem_rsp_data;
            pc_q[wr_ptr]    <= rsp_pc;
        end
    end

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = fetch_pc;
    assign bus.out_valid      = (count != '0);
    assign bus.out_opcode     = instr_q[rd_ptr][31:26];
    assign bus.out_rs         = instr_q[rd_ptr][25:21];
    assign bus.out_rt         = instr_q[rd_ptr][20:16];
    assign bus.out_imm        = instr_q[rd_ptr][15:0];
    assign bus.out_pc         = pc_q[rd_ptr];
    assign bus.out_pc_next    = pc_q[rd_ptr] + STEP;
endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: directed phases with randomized handshakes,
// checked against a queue-level model of the fetch stream.
module tb_fetch_queue_unit;
    localparam int AW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_queue_unit_if #(.ADDR_W(AW), .WIDTH(32)) bus ();

    fetch_queue_unit #(
        .ADDR_W(AW), .QDEPTH(4), .PC_STEP(4), .RESET_PC(0), .WIDTH(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [7:0] addr;
        bit         stale;
        int         due;
    } req_t;

    req_t       pend[$];
    logic [7:0] mq[$];
    logic [7:0] m_fetch_pc;
    int         cyc;
    int         lat_min, lat_max, rdy_pct, ord_pct;
    int         checks, errors;

    function automatic logic [31:0] word(input logic [7:0] a);
        return {a ^ 8'hC3, ~a, a + 8'h33, a};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic reset_checks();
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check("rst_req_addr",  32'(bus.imem_req_addr), 32'd0);
        check("rst_out_pc",    32'(bus.out_pc), 32'd0);
        check("rst_opcode",    32'(bus.out_opcode), 32'd0);
        check("rst_rs",        32'(bus.out_rs), 32'd0);
        check("rst_rt",        32'(bus.out_rt), 32'd0);
        check("rst_imm",       32'(bus.out_imm), 32'd0);
    endtask

    task automatic idle_inputs();
        bus.redirect_valid = 1'b0;
        bus.redirect_addr  = '0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.out_ready      = 1'b0;
    endtask

    // One clock cycle: drive inputs, compare outputs, then advance the model
    // to what the coming rising edge should produce.
    task automatic step(input bit redir, input logic [7:0] raddr);
        bit          rdy, ordy, rsp, exp_rv;
        req_t        fr;
        logic [31:0] w;
        logic [7:0]  nxt;
        @(negedge clk);
        rdy  = ($urandom_range(99) < rdy_pct);
        ordy = ($urandom_range(99) < ord_pct);
        rsp  = (pend.size() != 0) && (pend[0].due <= cyc);
        bus.redirect_valid = redir;
        bus.redirect_addr  = raddr;
        bus.imem_req_ready = rdy;
        bus.out_ready      = ordy;
        bus.imem_rsp_valid = rsp;
        bus.imem_rsp_data  = rsp ? word(pend[0].addr) : $urandom();
        #1;
        exp_rv = (mq.size() + pend.size()) < 4;
        check("req_valid", 32'(bus.imem_req_valid), 32'(exp_rv));
        check("req_addr",  32'(bus.imem_req_addr), 32'(m_fetch_pc));
        check("out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            w   = word(mq[0]);
            nxt = mq[0] + 8'd4;
            check("out_pc",      32'(bus.out_pc), 32'(mq[0]));
            check("out_pc_next", 32'(bus.out_pc_next), 32'(nxt));
            check("out_opcode",  32'(bus.out_opcode), 32'(w[31:26]));
            check("out_rs",      32'(bus.out_rs), 32'(w[25:21]));
            check("out_rt",      32'(bus.out_rt), 32'(w[20:16]));
            check("out_imm",     32'(bus.out_imm), 32'(w[15:0]));
        end
        if (rsp)
            fr = pend.pop_front();
        if (exp_rv && rdy) begin
            pend.push_back('{m_fetch_pc, 1'b0, cyc + int'($urandom_range(lat_max, lat_min))});
            m_fetch_pc = m_fetch_pc + 8'd4;
        end
        if (redir) begin
            mq.delete();
            foreach (pend[i]) pend[i].stale = 1'b1;
            m_fetch_pc = raddr;
        end else begin
            if (mq.size() != 0 && ordy)
                void'(mq.pop_front());
            if (rsp && !fr.stale)
                mq.push_back(fr.addr);
        end
        cyc++;
    endtask

    initial begin
        int first;
        checks = 0; errors = 0; cyc = 0;
        m_fetch_pc = 8'h00;
        lat_min = 1; lat_max = 1; rdy_pct = 100; ord_pct = 100;
        idle_inputs();
        rst = 1'b1;
        #1 rst = 1'b0;
        #11;
        reset_checks();
        @(posedge clk);
        #2 rst = 1'b1;

        // Full-rate stream at latency 1
        repeat (20) step(1'b0, 8'h00);

        // Back-pressure fills the queue, then drains in order
        ord_pct = 0;
        repeat (10) step(1'b0, 8'h00);
        ord_pct = 100;
        repeat (10) step(1'b0, 8'h00);

        // Latency 3: quiesce, put two requests in flight, redirect to 0x40
        lat_min = 3; lat_max = 3; rdy_pct = 0;
        step(1'b1, 8'h20);
        repeat (6) step(1'b0, 8'h00);
        rdy_pct = 100;
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        rdy_pct = 0;
        step(1'b1, 8'h40);
        rdy_pct = 100;
        first = 0;
        for (int k = 1; k <= 8; k++) begin
            step(1'b0, 8'h00);
            if (first == 0 && bus.out_valid === 1'b1)
                first = k;
        end
        check("redirect_latency", 32'(first), 32'd5);
        repeat (6) step(1'b0, 8'h00);

        // Redirect coinciding with response, accept and pop
        lat_min = 1; lat_max = 1;
        repeat (8) step(1'b0, 8'h00);
        step(1'b1, 8'h80);
        repeat (6) step(1'b0, 8'h00);

        // Address wrap
        step(1'b1, 8'hF8);
        repeat (12) step(1'b0, 8'h00);

        // Randomized handshakes, latencies and redirects
        lat_min = 1; lat_max = 4; rdy_pct = 70; ord_pct = 60;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(19) == 0)
                step(1'b1, 8'($urandom()) & 8'hFC);
            else
                step(1'b0, 8'h00);
        end

        // Asynchronous reset mid-stream with requests in flight
        lat_min = 2; lat_max = 2; rdy_pct = 100; ord_pct = 100;
        repeat (6) step(1'b0, 8'h00);
        #1 rst = 1'b0;
        #1;
        reset_checks();
        idle_inputs();
        pend.delete();
        mq.delete();
        m_fetch_pc = 8'h00;
        @(posedge clk);
        #2 rst = 1'b1;
        repeat (12) step(1'b0, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
